// File: rtl/sub_divider_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package sub_divider_seq_pkg;

  localparam int unsigned Width = 16;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [Width-1:0] DivZeroQ = 16'hFFFF;

endpackage

// File: rtl/sub_divider_seq_sub.sv
// 16-bit ripple subtractor: diff = a - b computed as a + ~b + 1.
// carry_o = 1 means no borrow; overflow_o is the signed overflow flag.
module sub_divider_seq_sub
  import sub_divider_seq_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             carry_o,
  output logic             overflow_o
);

  always_comb begin : p_ripple
    logic c;
    logic c_msb;
    diff_o = '0;
    c      = 1'b1;
    c_msb  = 1'b0;
    for (int i = 0; i < Width; i++) begin
      diff_o[i] = a_i[i] ^ ~b_i[i] ^ c;
      if (i == Width - 1) begin
        c_msb = c;
      end
      c = (a_i[i] & ~b_i[i]) | (c & (a_i[i] ^ ~b_i[i]));
    end
    carry_o    = c;
    overflow_o = c ^ c_msb;
  end

endmodule

// File: rtl/sub_divider_seq.sv
// Multi-cycle unsigned restoring divider; one ripple subtractor iterated 16 times.
// busy/done are decoded straight from the state register, so start has no path to them.
module sub_divider_seq
  import sub_divider_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] quotient,
  output logic [Width-1:0] remainder,
  output logic             div_by_zero
);

  state_e state_q, state_d;

  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] quot_q, quot_d;
  logic [Width-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [Width-1:0] shifted;
  logic [Width-1:0] sub_diff;
  logic             sub_carry;
  logic             unused_sub_ovf;
  logic             take;
  logic             accept;

  assign accept  = (state_q == StIdle) && start;
  assign shifted = {rem_q[Width-2:0], q_q[Width-1]};
  // A set rem MSB means the true 17-bit shifted value exceeds dvs regardless of borrow.
  assign take    = rem_q[Width-1] | sub_carry;

  sub_divider_seq_sub u_sub (
    .a_i        (shifted),
    .b_i        (dvs_q),
    .diff_o     (sub_diff),
    .carry_o    (sub_carry),
    .overflow_o (unused_sub_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (divisor == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (cnt_q == {CntW{1'b1}}) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_comb begin
    rem_d  = rem_q;
    q_d    = q_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dbz_d  = dbz_q;
    if (accept) begin
      rem_d = '0;
      q_d   = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      dbz_d = 1'b0;
      if (divisor == '0) begin
        quot_d = DivZeroQ;
        remo_d = dividend;
        dbz_d  = 1'b1;
      end
    end else if (state_q == StRun) begin
      rem_d = take ? sub_diff : shifted;
      q_d   = {q_q[Width-2:0], take};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == {CntW{1'b1}}) begin
        quot_d = q_d;
        remo_d = rem_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sub_divider_seq.sv
// Scoreboard bench for sub_divider_seq: expected results queued at accept, checked on done.
module tb_sub_divider_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  sub_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   dones = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_run++;
      else busy_run = 0;
      if (done === 1'b1) begin
        dones++;
        check_eq("done_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("quotient", quotient, mon_e.q);
          check_eq("remainder", remainder, mon_e.r);
          check_eq("div_by_zero", div_by_zero, mon_e.dbz);
          check_eq("latency_edges", cyc - mon_e.acc_cyc, mon_e.lat);
          check_eq("busy_cycles", busy_run, mon_e.lat + 1);
          if (!mon_e.dbz) begin
            check_eq("identity", 32'(quotient) * 32'(mon_e.b) + 32'(remainder), 32'(mon_e.a));
            check_eq("rem_lt_dvs", (remainder < mon_e.b), 1);
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("issue_timeout", n, 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.a       = a;
    e.b       = b;
    e.dbz     = (b == 16'd0);
    e.q       = (b == 16'd0) ? 16'hFFFF : a / b;
    e.r       = (b == 16'd0) ? a : a % b;
    e.acc_cyc = cyc + 1;
    e.lat     = (b == 16'd0) ? 0 : 16;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_ignored(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", (n < 400), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [15:0] a;
    logic [15:0] b;

    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'd100, 16'd7);
    drain();
    issue(16'hFFFF, 16'd1);
    issue(16'h8000, 16'hFFFF);
    issue(16'hFFFF, 16'hFFFE);
    drain();
    issue(16'd1234, 16'd0);
    issue(16'd17, 16'd4);
    drain();

    // Requests while busy (RUN and DONE) must be dropped.
    d0 = dones;
    issue(16'd50, 16'd5);
    repeat (5) @(negedge clk);
    pulse_ignored(16'd9, 16'd3);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_done", done, 1);
    pulse_ignored(16'd9, 16'd3);
    drain();
    repeat (25) @(negedge clk);
    check_eq("ignored_one_done", dones - d0, 1);

    // Abort after eight iterations.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    d0 = dones;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_quotient", quotient, 0);
    check_eq("abort_remainder", remainder, 0);
    check_eq("abort_dbz", div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", dones - d0, 0);
    issue(16'd1000, 16'd3);
    drain();

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      if (i % 4 == 0) b = 16'($urandom_range(1, 15));
      else b = 16'($urandom_range(1, 65535));
      issue(a, b);
    end
    drain();
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
